// File: rtl/key_debounce.sv
// Synchronises and debounces N_KEYS raw piano keys into a clean chord vector with one-cycle press/release strobes.
// Optional sustain pedal (define KEY_SUSTAIN_EN) holds released keys in the chord until the pedal lifts.
module key_debounce #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef KEY_SUSTAIN_EN
  input  logic              sustain,
`endif
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] chord,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              chord_changed
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_chord;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic              r_changed;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];

  logic [N_KEYS-1:0] w_deb;
  logic [N_KEYS-1:0] w_accept;
  logic [N_KEYS-1:0] w_deb_next;
  logic [N_KEYS-1:0] w_chord_next;

  // w_deb is the debounced key level the counters compare against.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_accept[i] = (r_sync2[i] != w_deb[i]) && (r_cnt[i] == LP_LAST);
    end
  end

  assign w_deb_next = w_deb ^ w_accept;

`ifdef KEY_SUSTAIN_EN
  logic              r_sus1;
  logic              r_sus2;
  logic [N_KEYS-1:0] r_deb;
  logic [N_KEYS-1:0] r_pend;
  logic [N_KEYS-1:0] w_pend_next;

  assign w_deb = r_deb;

  // Pending releases only survive while the pedal is down; lifting it drops them all at once.
  always_comb begin
    w_pend_next = '0;
    if (r_sus2) begin
      w_pend_next = (r_pend | (w_accept & ~r_sync2)) & ~(w_accept & r_sync2);
    end
  end

  assign w_chord_next = w_deb_next | w_pend_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sus1 <= 1'b0;
      r_sus2 <= 1'b0;
      r_deb  <= '0;
      r_pend <= '0;
    end else begin
      r_sus1 <= sustain;
      r_sus2 <= r_sus1;
      r_deb  <= w_deb_next;
      r_pend <= w_pend_next;
    end
  end
`else
  assign w_deb        = r_chord;
  assign w_chord_next = w_deb_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_chord   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= keys_raw;
      r_sync2   <= r_sync1;
      r_chord   <= w_chord_next;
      r_press   <= w_chord_next & ~r_chord;
      r_release <= r_chord & ~w_chord_next;
      r_changed <= |(w_chord_next ^ r_chord);
      // Clearing on acceptance keeps the counter below DEBOUNCE_CYCLES, so it never wraps.
      for (int i = 0; i < N_KEYS; i++) begin
        if ((r_sync2[i] == w_deb[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign chord         = r_chord;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign chord_changed = r_changed;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=4, plus a DEBOUNCE_CYCLES=1 instance.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keys_raw = 8'h00;
  logic [7:0] chord, press_pulse, release_pulse;
  logic       chord_changed;
  logic [7:0] keys1 = 8'h00;
  logic [7:0] chord1, press1, rel1;
  logic       chg1;
`ifdef KEY_SUSTAIN_EN
  logic       sustain = 1'b0;
`endif

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] chord;
    logic [7:0] press;
    logic [7:0] rel;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         timeout;
    logic [7:0] chord;
    logic [7:0] press;
    logic [7:0] rel;
    logic       chg_next;
    logic [7:0] press_next;
    logic [7:0] rel_next;
  } obs_t;

  exp_t sb[$];

  key_debounce #(.N_KEYS(8), .DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef KEY_SUSTAIN_EN
    .sustain       (sustain),
`endif
    .keys_raw      (keys_raw),
    .chord         (chord),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .chord_changed (chord_changed)
  );

  key_debounce #(.N_KEYS(8), .DEBOUNCE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef KEY_SUSTAIN_EN
    .sustain       (1'b0),
`endif
    .keys_raw      (keys1),
    .chord         (chord1),
    .press_pulse   (press1),
    .release_pulse (rel1),
    .chord_changed (chg1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [7:0] ch, input logic [7:0] pr, input logic [7:0] rl);
    exp_t e;
    e.cyc = c; e.chord = ch; e.press = pr; e.rel = rl;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next chord_changed strobe and captures it plus the following cycle.
  task automatic observe(output obs_t o);
    o.timeout = 1'b1; o.cyc = -1; o.chord = 8'h00; o.press = 8'h00; o.rel = 8'h00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (chord_changed === 1'b1) begin
        o.timeout = 1'b0; o.cyc = cyc; o.chord = chord; o.press = press_pulse; o.rel = release_pulse;
        break;
      end
    end
    @(negedge clk);
    o.chg_next = chord_changed; o.press_next = press_pulse; o.rel_next = release_pulse;
  endtask

  task automatic test_reset();
    obs_t o; exp_t e; int t0;
    keys_raw = 8'hFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({chord, press_pulse, release_pulse, chord_changed} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_hold: chord=%h press=%h rel=%h chg=%b, want all 0", chord, press_pulse, release_pulse, chord_changed);
    end
    rst_n = 1'b1; t0 = cyc;
    push(t0 + 6, 8'hFF, 8'hFF, 8'h00);
    @(negedge clk);
    n_tests++;
    if ({chord, press_pulse, release_pulse, chord_changed} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_first_cycle: chord=%h chg=%b, want 0", chord, chord_changed);
    end
    observe(o); e = sb.pop_front();
    n_tests++;
    if (o.timeout || o.cyc !== e.cyc || o.chord !== e.chord || o.press !== e.press || o.rel !== e.rel) begin
      n_fail++;
      $display("FAIL reset_debounce: cyc=%0d chord=%h press=%h rel=%h, want cyc=%0d chord=%h press=%h rel=%h",
               o.cyc, o.chord, o.press, o.rel, e.cyc, e.chord, e.press, e.rel);
    end
    n_tests++;
    if ({o.chg_next, o.press_next, o.rel_next} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_single_pulse: next chg=%b press=%h rel=%h, want 0", o.chg_next, o.press_next, o.rel_next);
    end
  endtask

  // Steps: keys to drive, expected chord, press and release vectors.
  task automatic run_steps(input string name, input logic [7:0] k [], input logic [7:0] ch [],
                           input logic [7:0] pr [], input logic [7:0] rl []);
    obs_t o; exp_t e; int t0;
    for (int n = 0; n < k.size(); n++) begin
      @(negedge clk); keys_raw = k[n]; t0 = cyc;
      push(t0 + 6, ch[n], pr[n], rl[n]);
      observe(o); e = sb.pop_front();
      n_tests++;
      if (o.timeout || o.cyc !== e.cyc || o.chord !== e.chord || o.press !== e.press || o.rel !== e.rel) begin
        n_fail++;
        $display("FAIL %s_step%0d: cyc=%0d chord=%h press=%h rel=%h, want cyc=%0d chord=%h press=%h rel=%h",
                 name, n, o.cyc, o.chord, o.press, o.rel, e.cyc, e.chord, e.press, e.rel);
      end
      n_tests++;
      if ({o.chg_next, o.press_next, o.rel_next} !== 17'd0) begin
        n_fail++;
        $display("FAIL %s_single_pulse%0d: next chg=%b press=%h rel=%h, want 0", name, n, o.chg_next, o.press_next, o.rel_next);
      end
    end
  endtask

  task automatic test_release();
    run_steps("release", '{8'h01, 8'h00}, '{8'h01, 8'h00}, '{8'h00, 8'h00}, '{8'hFE, 8'h01});
  endtask

  task automatic test_simultaneous();
    run_steps("simul", '{8'h22, 8'h00}, '{8'h22, 8'h00}, '{8'h22, 8'h00}, '{8'h00, 8'h22});
  endtask

  task automatic test_bounce();
    obs_t o; exp_t e; int tf; int pulses;
    logic [3:0] pat;
    pat = 4'b0101;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      keys_raw[2] = pat[n];
      repeat (2) @(negedge clk);
    end
    keys_raw = 8'h04; tf = cyc;
    push(tf + 6, 8'h04, 8'h04, 8'h00);
    observe(o); e = sb.pop_front();
    n_tests++;
    if (o.timeout || o.cyc !== e.cyc || o.chord !== e.chord || o.press !== e.press || o.rel !== e.rel) begin
      n_fail++;
      $display("FAIL bounce_accept: cyc=%0d chord=%h press=%h rel=%h, want cyc=%0d chord=%h press=%h rel=%h",
               o.cyc, o.chord, o.press, o.rel, e.cyc, e.chord, e.press, e.rel);
    end
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (chord_changed === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || chord !== 8'h04) begin
      n_fail++;
      $display("FAIL bounce_extra_pulse: pulses=%0d chord=%h, want 0 and 04", pulses, chord);
    end
  endtask

  task automatic test_async_reset();
    obs_t o; exp_t e; int tr;
    @(negedge clk); keys_raw = 8'h80;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (chord !== 8'h00 || chord_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_clear: chord=%h chg=%b, want 00 and 0", chord, chord_changed);
    end
    #1 rst_n = 1'b1; tr = cyc;
    push(tr + 6, 8'h80, 8'h80, 8'h00);
    observe(o); e = sb.pop_front();
    n_tests++;
    if (o.timeout || o.cyc !== e.cyc || o.chord !== e.chord || o.press !== e.press || o.rel !== e.rel) begin
      n_fail++;
      $display("FAIL async_reset_redebounce: cyc=%0d chord=%h press=%h rel=%h, want cyc=%0d chord=%h press=%h rel=%h",
               o.cyc, o.chord, o.press, o.rel, e.cyc, e.chord, e.press, e.rel);
    end
    run_steps("async_cleanup", '{8'h00}, '{8'h00}, '{8'h00}, '{8'h80});
  endtask

  task automatic test_min_debounce();
    @(negedge clk); keys1 = 8'h01;
    repeat (2) @(negedge clk);
    n_tests++;
    if (chord1 !== 8'h00) begin
      n_fail++;
      $display("FAIL min_debounce_early: chord1=%h, want 00", chord1);
    end
    @(negedge clk);
    n_tests++;
    if (chord1 !== 8'h01 || press1 !== 8'h01 || chg1 !== 1'b1) begin
      n_fail++;
      $display("FAIL min_debounce_accept: chord1=%h press1=%h chg1=%b, want 01 01 1", chord1, press1, chg1);
    end
  endtask

`ifdef KEY_SUSTAIN_EN
  task automatic test_sustain();
    obs_t o; exp_t e; int ts; int pulses;
    @(negedge clk); sustain = 1'b1;
    run_steps("sustain_press", '{8'h08}, '{8'h08}, '{8'h08}, '{8'h00});
    @(negedge clk); keys_raw = 8'h00;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (chord_changed === 1'b1 || release_pulse !== 8'h00) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || chord !== 8'h08) begin
      n_fail++;
      $display("FAIL sustain_hold: pulses=%0d chord=%h, want 0 and 08", pulses, chord);
    end
    sustain = 1'b0; ts = cyc;
    push(ts + 3, 8'h00, 8'h00, 8'h08);
    observe(o); e = sb.pop_front();
    n_tests++;
    if (o.timeout || o.cyc !== e.cyc || o.chord !== e.chord || o.press !== e.press || o.rel !== e.rel) begin
      n_fail++;
      $display("FAIL sustain_lift: cyc=%0d chord=%h press=%h rel=%h, want cyc=%0d chord=%h press=%h rel=%h",
               o.cyc, o.chord, o.press, o.rel, e.cyc, e.chord, e.press, e.rel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_simultaneous();
    test_bounce();
    test_async_reset();
    test_min_debounce();
`ifdef KEY_SUSTAIN_EN
    test_sustain();
`endif
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream stage of the frequency divider bank.
- Takes 8 raw, bouncing piano-key inputs and synchronises each one to clk.
- Debounces each key independently and presents a clean 8-bit chord vector (bit i = key i held) to the divider stage.
- Also emits one-cycle press/release strobes for note-event logic.

Parameters:
- N_KEYS, 8, number of keys; width of keys_raw, chord and the strobe vectors.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key change is accepted (1 ms at 50 MHz). Legal range 1..2^CNT_W-1.
- CNT_W, 16, width of each per-key stability counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- keys_raw  input  N_KEYS  raw key levels, asynchronous to clk; 1 = pressed.
- chord  output  N_KEYS  debounced key state; feeds the divider bank's chord input.
- press_pulse  output  N_KEYS  bit i high for exactly one cycle when chord[i] goes 0->1.
- release_pulse  output  N_KEYS  bit i high for exactly one cycle when chord[i] goes 1->0.
- chord_changed  output  1  high for one cycle whenever any chord bit changes (OR of both strobe vectors).

Behaviour:
- Reset: rst_n low clears, asynchronously and immediately, all of: sync flops, counters, chord, press_pulse, release_pulse, chord_changed. All outputs read 0 during reset and in the first cycle after deassertion.
- Synchroniser: 2-flop chain per key, sync1 <= keys_raw, s <= sync1. No other logic reads keys_raw.
- Per-key counter cnt[i] (CNT_W bits), evaluated every clock edge:
  - If s[i] == chord[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: chord[i] <= s[i], cnt[i] <= 0, and the matching strobe is asserted this edge.
  - Else: cnt[i] <= cnt[i]+1.
- Bounce rejection: any return of s[i] to chord[i] before acceptance restarts the count from 0. A pulse shorter than DEBOUNCE_CYCLES cycles never reaches chord.
- Latency: a clean step on keys_raw[i] set up before edge 0 appears on chord[i] after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges.
- Strobes: press_pulse, release_pulse and chord_changed are registered and asserted in the same cycle chord updates. They deassert on the next edge unless another key is accepted on that edge.
- Keys are fully independent. Simultaneous acceptance on several keys in one edge sets all the corresponding strobe bits together.
- Counter never wraps: it saturates by construction because it clears at DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: a change is accepted on the first mismatching edge.
- Reset mid-count discards the partial count. After reset, a key already held must debounce again from 0.

Optional Feature:
- Macro: KEY_SUSTAIN_EN.
- When defined:
  - Adds input port sustain (1 bit, synchronised by its own 2-flop chain, not debounced).
  - While the synchronised sustain is 1, a debounced release of key i leaves chord[i] at 1 and produces no release_pulse. That key's "pending release" bit is set instead.
  - A re-press of a pending key clears its pending bit with no press_pulse, since chord[i] is already 1.
  - On the synchronised sustain falling edge, every pending key drops chord to 0 and pulses release_pulse in one cycle, and chord_changed pulses.
  - Pending bits reset to 0.
- When undefined: no sustain port, and behaviour is exactly as above.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst_n=0 with keys_raw=8'hFF -> chord=0, all strobes 0. Release reset and hold keys -> chord=8'hFF after edge 6. press_pulse=8'hFF and chord_changed=1 for exactly that one cycle.
- Bounce rejection: keys_raw[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> chord[2] rises exactly 6 edges after the final rising step. Only one press_pulse[2] appears.
- Release: with chord=8'h01, drop keys_raw[0] -> chord=0 after 6 edges, release_pulse=8'h01 for one cycle, no press_pulse.
- Simultaneous: step keys 1 and 5 on the same cycle -> chord=8'h22 on the same edge, press_pulse=8'h22 in one cycle, chord_changed single pulse.
- Async reset mid-count: raise keys_raw[7], pull rst_n low for a fraction of a cycle after 3 edges -> chord stays 0. After release, chord[7]=1 only 6 full edges later.
- KEY_SUSTAIN_EN: sustain=1, press then release key 3 -> chord[3] stays 1 with no release_pulse. Drop sustain -> chord[3]=0 and release_pulse=8'h08 three edges after the sustain fall (2 synchroniser edges plus 1 update edge).
